frame_sync: RTL and testbench

Bit-level frame synchronizer placed directly downstream of the I/Q combiner in the QPSK demodulator. It consumes the recovered serial bit stream and its one-cycle bit strobe and searches for a fixed 16-bit header. After the header, it deserializes a fixed-length payload into bytes, MSB first. It reports byte-valid, frame-start and frame-done strobes to the packet/sink logic.

---
 rtl/frame_sync.sv | 113 +++++++++++
 tb/tb_frame_sync.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync.sv
// frame_sync: bit-level header search, then MSB-first payload deserialization into bytes.
// Latency: frame_start_o one cycle after the last header bit; byte_valid_o one cycle after the 8th bit of a byte.
// Backpressure: none; one bit is consumed per sync_flag_i strobe. Optional macro FRAME_SYNC_INV_HEADER_EN accepts the complemented header.
module frame_sync #(
    parameter logic [15:0] HEADER        = 16'hEB90,
    parameter int          PAYLOAD_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       demo_ser_i,
    input  logic       sync_flag_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_start_o,
    output logic       frame_done_o,
    output logic       locked_o,
    output logic       inverted_o
);

    localparam logic [0:0] SEARCH    = 1'b0;
    localparam logic [0:0] PAYLOAD   = 1'b1;
    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

    logic [0:0]  state;
    logic [15:0] sr;
    logic [4:0]  fill;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_cnt;
    logic [6:0]  byte_sr;
    logic        inv_q;

    logic [15:0] sr_next;
    logic [4:0]  fill_next;
    logic        hdr_hit;
    logic        inv_hit;
    logic [7:0]  byte_next;

    // Next-state values for the header shifter and the byte deserializer.
    always_comb begin
        sr_next   = {sr[14:0], demo_ser_i};
        fill_next = (fill == 5'd16) ? fill : fill + 5'd1;
        hdr_hit   = (fill_next == 5'd16) && (sr_next == HEADER);
`ifdef FRAME_SYNC_INV_HEADER_EN
        // A true header wins if both ever compare equal.
        inv_hit   = (fill_next == 5'd16) && (sr_next == ~HEADER) && !hdr_hit;
`else
        inv_hit   = 1'b0;
`endif
        byte_next = {byte_sr, demo_ser_i ^ inv_q};
    end

    // SEARCH/PAYLOAD state machine, deserializer and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SEARCH;
            sr            <= 16'h0000;
            fill          <= 5'd0;
            bit_cnt       <= 3'd0;
            byte_cnt      <= 8'd0;
            byte_sr       <= 7'd0;
            inv_q         <= 1'b0;
            byte_o        <= 8'h00;
            byte_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
        end else begin
            byte_valid_o  <= 1'b0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            if (sync_flag_i) begin
                case (state)
                    SEARCH: begin
                        sr   <= sr_next;
                        fill <= fill_next;
                        if (hdr_hit || inv_hit) begin
                            state         <= PAYLOAD;
                            frame_start_o <= 1'b1;
                            inv_q         <= inv_hit;
                        end
                    end
                    default: begin
                        byte_sr <= byte_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_o       <= byte_next;
                            byte_valid_o <= 1'b1;
                            byte_cnt     <= byte_cnt + 8'd1;
                            if (byte_cnt == LAST_BYTE) begin
                                // Back to search with nothing of the payload kept,
                                // so the next header must arrive in full.
                                frame_done_o <= 1'b1;
                                state        <= SEARCH;
                                sr           <= 16'h0000;
                                fill         <= 5'd0;
                                bit_cnt      <= 3'd0;
                                byte_cnt     <= 8'd0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign locked_o = (state == PAYLOAD);

`ifdef FRAME_SYNC_INV_HEADER_EN
    assign inverted_o = inv_q;
`else
    assign inverted_o = 1'b0;
`endif

endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: directed frames against frame_sync with HEADER=EB90, PAYLOAD_BYTES=2.
// Inputs driven 1 time unit after posedge; outputs sampled on negedge by a monitor and inline after stimulus.
// Expected bytes and strobe counts are hand-computed per scenario.
module tb_frame_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       demo_ser_i = 1'b0;
    logic       sync_flag_i = 1'b0;
    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       frame_start_o;
    logic       frame_done_o;
    logic       locked_o;
    logic       inverted_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] got_bytes[$];
    int         n_start = 0;
    int         n_done  = 0;
    logic       prev_start = 1'b0;
    logic       prev_done  = 1'b0;

    frame_sync #(.HEADER(16'hEB90), .PAYLOAD_BYTES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .demo_ser_i    (demo_ser_i),
        .sync_flag_i   (sync_flag_i),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid_o),
        .frame_start_o (frame_start_o),
        .frame_done_o  (frame_done_o),
        .locked_o      (locked_o),
        .inverted_o    (inverted_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Negedge monitor: collects bytes/strobes and checks pulse shape.
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid_o) got_bytes.push_back(byte_o);
            if (frame_start_o) begin
                n_start++;
                chk("start_single_cycle", {31'd0, prev_start}, 32'd0);
            end
            if (frame_done_o) begin
                n_done++;
                chk("done_with_valid", {31'd0, byte_valid_o}, 32'd1);
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            end
        end
        prev_start = frame_start_o;
        prev_done  = frame_done_o;
    end

    task automatic send_bit(input logic b, input int gap);
        demo_ser_i  = b;
        sync_flag_i = 1'b1;
        @(posedge clk); #1;
        sync_flag_i = 1'b0;
        repeat (gap) begin
            demo_ser_i = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic send_word(input logic [15:0] v, input int gap);
        for (int i = 15; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sync_flag_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_bytes.delete();
        n_start = 0;
        n_done  = 0;
        @(posedge clk); #1;
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3, input int n);
        logic [7:0] exp_b[4];
        exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3;
        chk({tag, "_count"}, 32'(got_bytes.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_bytes.size()) chk({tag, "_byte"}, {24'd0, got_bytes[i]}, {24'd0, exp_b[i]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_o"}, {24'd0, byte_o}, 32'h00);
        chk({tag, "_valid"},  {31'd0, byte_valid_o}, 32'd0);
        chk({tag, "_start"},  {31'd0, frame_start_o}, 32'd0);
        chk({tag, "_done"},   {31'd0, frame_done_o}, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked_o}, 32'd0);
        chk({tag, "_inv"},    {31'd0, inverted_o}, 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        do_reset();

        // Single frame: 3 random bits, header, A5, 3C at one-cycle spacing
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 0);
        send_word(16'hEB90, 0);
        chk("t1_start", {31'd0, frame_start_o}, 32'd1);
        chk("t1_locked", {31'd0, locked_o}, 32'd1);
        send_byte(8'hA5, 0);
        chk("t1_valid_a5", {31'd0, byte_valid_o}, 32'd1);
        chk("t1_byte_a5", {24'd0, byte_o}, 32'hA5);
        chk("t1_no_done_a5", {31'd0, frame_done_o}, 32'd0);
        send_byte(8'h3C, 0);
        chk("t1_byte_3c", {24'd0, byte_o}, 32'h3C);
        chk("t1_done", {31'd0, frame_done_o}, 32'd1);
        chk("t1_unlocked", {31'd0, locked_o}, 32'd0);
        @(posedge clk); #1;
        chk("t1_done_clear", {31'd0, frame_done_o}, 32'd0);
        chk("t1_byte_hold", {24'd0, byte_o}, 32'h3C);
        check_bytes("t1", 8'hA5, 8'h3C, 8'h00, 8'h00, 2);
        chk("t1_nstart", 32'(n_start), 32'd1);
        chk("t1_ndone", 32'(n_done), 32'd1);

        // Back-to-back frames with no dead bit
        do_reset();
        send_word(16'hEB90, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_word(16'hEB90, 0);
        chk("t2_start2", {31'd0, frame_start_o}, 32'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (2) @(posedge clk);
        #1;
        check_bytes("t2", 8'hA5, 8'h3C, 8'h11, 8'h22, 4);
        chk("t2_nstart", 32'(n_start), 32'd2);
        chk("t2_ndone", 32'(n_done), 32'd2);

        // Header pattern inside payload is data
        do_reset();
        send_word(16'hEB90, 0);
        send_byte(8'hEB, 0);
        send_byte(8'h90, 0);
        chk("t3_nstart_mid", 32'(n_start), 32'd1);
        send_word(16'hEB90, 0);
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        repeat (2) @(posedge clk);
        #1;
        check_bytes("t3", 8'hEB, 8'h90, 8'h55, 8'hAA, 4);
        chk("t3_nstart", 32'(n_start), 32'd2);

        // Complemented header
        do_reset();
        send_word(16'h146F, 0);
`ifdef FRAME_SYNC_INV_HEADER_EN
        chk("t4_inv", {31'd0, inverted_o}, 32'd1);
        send_byte(8'h5A, 0);
        send_byte(8'hC3, 0);
        repeat (2) @(posedge clk);
        #1;
        check_bytes("t4", 8'hA5, 8'h3C, 8'h00, 8'h00, 2);
        chk("t4_nstart", 32'(n_start), 32'd1);
        chk("t4_inv_hold", {31'd0, inverted_o}, 32'd1);
`else
        chk("t4_inv", {31'd0, inverted_o}, 32'd0);
        send_byte(8'h5A, 0);
        send_byte(8'hC3, 0);
        repeat (2) @(posedge clk);
        #1;
        check_bytes("t4", 8'h00, 8'h00, 8'h00, 8'h00, 0);
        chk("t4_nstart", 32'(n_start), 32'd0);
        chk("t4_locked", {31'd0, locked_o}, 32'd0);
`endif

        // Reset mid-frame, partial byte pending
        do_reset();
        send_word(16'hEB90, 0);
        send_byte(8'hA5, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("t5_in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_bytes.delete();
        n_start = 0;
        n_done  = 0;
        send_word(16'hEB90, 0);
        chk("t5_start", {31'd0, frame_start_o}, 32'd1);
        send_byte(8'hC3, 0);
        send_byte(8'h7E, 0);
        chk("t5_done", {31'd0, frame_done_o}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_bytes("t5", 8'hC3, 8'h7E, 8'h00, 8'h00, 2);

        // Sparse strobes, random data between strobes
        do_reset();
        send_word(16'hEB90, 100);
        send_byte(8'hA5, 100);
        send_byte(8'h3C, 100);
        check_bytes("t6", 8'hA5, 8'h3C, 8'h00, 8'h00, 2);
        chk("t6_nstart", 32'(n_start), 32'd1);
        chk("t6_ndone", 32'(n_done), 32'd1);
        chk("t6_locked", {31'd0, locked_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
